pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline sequencing controller for the five-stage ysyx22040228 core. It gathers stall requests from the IF, ID, EX (multi-cycle MUL/DIV) and MEM stages plus the MEM-stage redirect/trap flush, and drives the per-register hold vector `stall_ctrl` and kill vector `bubble_ctrl`. It owns the multi-cycle MDU latency counter and defers flushes that arrive while memory is busy. All pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) are slaves of this block.

## Interface
- `MDU_LAT`, default 33: total EX occupancy of one MUL/DIV op in cycles; legal range 2..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req_stall`  in  1  fetch data not ready (level).
- `id_req_stall`  in  1  load-use hazard detected in ID (level).
- `ex_mdu_start`  in  1  one-cycle pulse: MUL/DIV op entered EX this cycle.
- `mem_req_stall`  in  1  data memory access outstanding (level).
- `flush_req`  in  1  one-cycle pulse: MEM-stage redirect or trap.
- `stall_ctrl`  out  5  hold vector, 1 = register keeps value; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- `bubble_ctrl`  out  5  1 = register loads NOP/zero this cycle; same bit mapping.
- `flush_ctrl`  out  1  PC takes redirect target this cycle.
- `mdu_busy`  out  1  MDU counter nonzero.

## Operation
- Priority: deepest active stall wins (MEM > EX > ID > IF). Stall at stage k holds all earlier registers and bubbles the next register:
  - MEM: `stall_ctrl`=01111, `bubble_ctrl`=10000.
  - EX (`ex_mdu_start` or `mdu_busy`): `stall_ctrl`=00111, `bubble_ctrl`=01000.
  - ID: `stall_ctrl`=00011, `bubble_ctrl`=00100.
  - IF: `stall_ctrl`=00001, `bubble_ctrl`=00010.
  - none: both 00000.
- `stall_ctrl[4]` is never 1; the MEM/WB register always advances or bubbles.
- MDU counter `cnt` (8 bit): on `ex_mdu_start`, load `MDU_LAT`-1; otherwise decrement while nonzero. It decrements regardless of MEM stall.
- Flush FSM, states RUN and PEND:
  - RUN, `flush_req` with `mem_req_stall`=0: perform flush, stay RUN.
  - RUN, `flush_req` with `mem_req_stall`=1: go to PEND and apply the MEM stall vectors.
  - PEND: hold until `mem_req_stall`=0, then perform the flush that cycle and return to RUN.
  - A `flush_req` arriving in PEND merges with the pending flush (single flush).
- Performing a flush:
  - `flush_ctrl`=1, `stall_ctrl`=00000, `bubble_ctrl`=01110 (kills IF/ID, ID/EX, EX/MEM).
  - `cnt` cleared next edge; a coincident `ex_mdu_start` is ignored.
  - The flush overrides IF, ID and EX stall requests.

## Timing
- `stall_ctrl`, `bubble_ctrl` and `flush_ctrl` are combinational from inputs, FSM state and `cnt`; same-cycle response, zero latency.
- `cnt` and FSM state update on the `clk` rising edge.
- MDU: `ex_mdu_start` at cycle t gives EX stall in cycles t..t+`MDU_LAT`-1; EX advances at t+`MDU_LAT`. `mdu_busy` is high t+1..t+`MDU_LAT`-1.
- `ex_mdu_start` while `cnt`≠0 is a protocol error; the counter reloads.
- Deferred flush performs in the first cycle with `mem_req_stall`=0 after PEND entry, at the earliest t+1.
- Reset, including mid-MDU or in PEND: state RUN, `cnt`=0. All outputs 0 in the cycle after the reset edge, assuming no stall or flush inputs that cycle.

## Configuration
- `YSYX22040228_PIPE_PERF_EN` defined adds two outputs, both reset to 0 and wrapping silently:
  - `perf_stall_cyc [63:0]`: increments every cycle `stall_ctrl[0]`=1.
  - `perf_flush_cnt [31:0]`: increments per performed flush.
- Undefined: those ports and counters do not exist; the rest of the behaviour is identical.

## Test plan
- `id_req_stall`=1 for 2 cycles, no other requests -> `stall_ctrl`=00011, `bubble_ctrl`=00100 in both cycles; 00000/00000 the cycle after.
- `MDU_LAT`=33, `ex_mdu_start` at t -> `stall_ctrl`=00111 for t..t+32 (33 cycles), `mdu_busy` high t+1..t+32, 00000 at t+33.
- `mem_req_stall` and `if_req_stall` both 1 -> `stall_ctrl`=01111, `bubble_ctrl`=10000.
- `flush_req` at t while `mem_req_stall`=1 for t..t+3 -> `flush_ctrl`=0 t..t+3; at t+4 `flush_ctrl`=1, `bubble_ctrl`=01110.
- `flush_req` at cycle t+5 of an MDU op -> `bubble_ctrl`=01110 at t+5; `mdu_busy`=0 from t+6 on.
- `rst` asserted mid-MDU and in PEND -> next cycle `mdu_busy`=0 and all outputs 0; perf counters (macro on) read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - central pipeline sequencing controller for the five-stage core.
//
// Collects stall requests from IF, ID, EX (multi-cycle MUL/DIV) and MEM, plus
// the MEM-stage redirect/trap flush. It then drives the per-register hold
// vector and kill vector for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//
// Bit mapping for stall_ctrl / bubble_ctrl:
//   bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
//
// Parameters:
//   MDU_LAT        total EX occupancy of one MUL/DIV op in cycles (2..255)
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   if_req_stall   fetch data not ready (level)
//   id_req_stall   load-use hazard in ID (level)
//   ex_mdu_start   one-cycle pulse, MUL/DIV op entered EX
//   mem_req_stall  data memory access outstanding (level)
//   flush_req      one-cycle pulse, MEM-stage redirect or trap
//   stall_ctrl     hold vector, 1 = register keeps its value
//   bubble_ctrl    kill vector, 1 = register loads NOP/zero
//   flush_ctrl     PC takes the redirect target this cycle
//   mdu_busy       MDU latency counter is nonzero
//
// Optional feature (macro YSYX22040228_PIPE_PERF_EN):
//   perf_stall_cyc [63:0]  cycles with the PC held
//   perf_flush_cnt [31:0]  number of flushes performed

module pipe_ctrl #(
    parameter int unsigned MDU_LAT = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req_stall,
    input  logic       id_req_stall,
    input  logic       ex_mdu_start,
    input  logic       mem_req_stall,
    input  logic       flush_req,
    output logic [4:0] stall_ctrl,
    output logic [4:0] bubble_ctrl,
    output logic       flush_ctrl,
    output logic       mdu_busy
`ifdef YSYX22040228_PIPE_PERF_EN
    ,
    output logic [63:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [7:0] MDU_RELOAD = 8'(MDU_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       flush_now;
    logic       ex_stall;

    // A flush is performed either immediately (RUN, memory idle) or as the
    // deferred flush leaving PEND once memory goes idle. A flush_req seen in
    // PEND needs no extra handling: it merges into the one already pending.
    always_comb begin
        flush_now = 1'b0;
        if (state_q == RUN) begin
            flush_now = flush_req && !mem_req_stall;
        end else begin
            flush_now = !mem_req_stall;
        end
    end

    // The start pulse itself already stalls EX, before the counter is loaded.
    assign ex_stall = ex_mdu_start || (cnt_q != 8'd0);
    assign mdu_busy = (cnt_q != 8'd0);

    // Output priority: a performed flush beats everything (MEM is idle in
    // that cycle by construction), then the deepest stalled stage wins.
    always_comb begin
        stall_ctrl  = 5'b00000;
        bubble_ctrl = 5'b00000;
        flush_ctrl  = 1'b0;
        if (flush_now) begin
            flush_ctrl  = 1'b1;
            bubble_ctrl = 5'b01110;
        end else if (mem_req_stall) begin
            stall_ctrl  = 5'b01111;
            bubble_ctrl = 5'b10000;
        end else if (ex_stall) begin
            stall_ctrl  = 5'b00111;
            bubble_ctrl = 5'b01000;
        end else if (id_req_stall) begin
            stall_ctrl  = 5'b00011;
            bubble_ctrl = 5'b00100;
        end else if (if_req_stall) begin
            stall_ctrl  = 5'b00001;
            bubble_ctrl = 5'b00010;
        end
    end

    // Next-state for the flush FSM and the MDU counter. The counter keeps
    // draining during a MEM stall; a flush clears it and swallows any
    // coincident start pulse since the op being started is being killed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN:     if (flush_req && mem_req_stall) state_d = PEND;
            PEND:    if (!mem_req_stall) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush_now) begin
            cnt_d = 8'd0;
        end else if (ex_mdu_start) begin
            cnt_d = MDU_RELOAD;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef YSYX22040228_PIPE_PERF_EN
    // Free-running event counters; they wrap silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= 64'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_ctrl[0]) perf_stall_cyc <= perf_stall_cyc + 64'd1;
            if (flush_now)     perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
